// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier: unpack/classify, significand
// multiply, normalise/round-to-nearest-even/pack. An output stall freezes every stage.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = EXP_W + MAN_W + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [3:0]   out_flags
);
  localparam int EW2 = EXP_W + 2;
  localparam int SW  = MAN_W + 1;
  localparam int PW  = 2 * MAN_W + 2;
  localparam logic signed [EW2-1:0] BIAS    = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EXP_TOP = EW2'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {CLS_NORM, CLS_NAN, CLS_INF, CLS_ZERO} cls_e;

  logic advance;

  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_sign_q, s1_sign_d;
  cls_e                  s1_cls_q, s1_cls_d;
  logic signed [EW2-1:0] s1_exp_q, s1_exp_d;
  logic [SW-1:0]         s1_sig_a_q, s1_sig_a_d;
  logic [SW-1:0]         s1_sig_b_q, s1_sig_b_d;

  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_sign_q, s2_sign_d;
  cls_e                  s2_cls_q, s2_cls_d;
  logic signed [EW2-1:0] s2_exp_q, s2_exp_d;
  logic [PW-1:0]         s2_prod_q, s2_prod_d;

  logic                  s3_valid_q, s3_valid_d;
  logic [W-1:0]          s3_result_q, s3_result_d;
  logic [3:0]            s3_flags_q, s3_flags_d;

  logic                  a_sign, b_sign;
  logic [EXP_W-1:0]      a_exp, b_exp;
  logic [MAN_W-1:0]      a_man, b_man;
  logic                  a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  logic                  prod_msb;
  logic [PW-2:0]         norm;
  logic                  guard, sticky, round_up;
  logic [MAN_W:0]        man_r;
  logic signed [EW2-1:0] exp_f;

  // The whole pipe moves together; bubbles are deliberately not collapsed.
  always_comb begin
    advance  = !(s3_valid_q && !out_ready);
    in_ready = advance;
  end

  always_comb begin
    a_sign = in_a[W-1];
    b_sign = in_b[W-1];
    a_exp  = in_a[W-2 -: EXP_W];
    b_exp  = in_b[W-2 -: EXP_W];
    a_man  = in_a[MAN_W-1:0];
    b_man  = in_b[MAN_W-1:0];
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    a_inf  = (a_exp == '1) && (a_man == '0);
    b_inf  = (b_exp == '1) && (b_man == '0);
    a_nan  = (a_exp == '1) && (a_man != '0);
    b_nan  = (b_exp == '1) && (b_man != '0);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_cls_d   = s1_cls_q;
    s1_exp_d   = s1_exp_q;
    s1_sig_a_d = s1_sig_a_q;
    s1_sig_b_d = s1_sig_b_q;
    if (advance) begin
      s1_valid_d = in_valid;
      s1_sign_d  = a_sign ^ b_sign;
      if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
        s1_cls_d = CLS_NAN;
      end else if (a_inf || b_inf) begin
        s1_cls_d = CLS_INF;
      end else if (a_zero || b_zero) begin
        s1_cls_d = CLS_ZERO;
      end else begin
        s1_cls_d = CLS_NORM;
      end
      s1_exp_d   = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;
      s1_sig_a_d = {1'b1, a_man};
      s1_sig_b_d = {1'b1, b_man};
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_cls_d   = s2_cls_q;
    s2_exp_d   = s2_exp_q;
    s2_prod_d  = s2_prod_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_cls_d   = s1_cls_q;
      s2_exp_d   = s1_exp_q;
      s2_prod_d  = PW'(s1_sig_a_q) * PW'(s1_sig_b_q);
    end
  end

  // Left-justify the product below its hidden bit so mantissa/guard/sticky
  // sit at fixed positions regardless of whether the product reached [2,4).
  always_comb begin
    prod_msb = s2_prod_q[PW-1];
    norm     = prod_msb ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
    guard    = norm[MAN_W];
    sticky   = |norm[MAN_W-1:0];
    round_up = guard && (sticky || norm[MAN_W+1]);
    man_r    = {1'b0, norm[PW-2 -: MAN_W]} + {{MAN_W{1'b0}}, round_up};
    exp_f    = s2_exp_q + $signed({{(EW2-1){1'b0}}, prod_msb})
                        + $signed({{(EW2-1){1'b0}}, man_r[MAN_W]});
  end

  always_comb begin
    s3_valid_d  = s3_valid_q;
    s3_result_d = s3_result_q;
    s3_flags_d  = s3_flags_q;
    if (advance) begin
      s3_valid_d = s2_valid_q;
      case (s2_cls_q)
        CLS_NAN: begin
          s3_result_d = QNAN;
          s3_flags_d  = 4'b1000;
        end
        CLS_INF: begin
          s3_result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          s3_flags_d  = 4'b0000;
        end
        CLS_ZERO: begin
          s3_result_d = {s2_sign_q, {(W-1){1'b0}}};
          s3_flags_d  = 4'b0000;
        end
        default: begin
          if (exp_f >= EXP_TOP) begin
            s3_result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            s3_flags_d  = 4'b0101;
          end else if (exp_f[EW2-1] || (exp_f == '0)) begin
            s3_result_d = {s2_sign_q, {(W-1){1'b0}}};
            s3_flags_d  = 4'b0011;
          end else begin
            s3_result_d = {s2_sign_q, exp_f[EXP_W-1:0], man_r[MAN_W-1:0]};
            s3_flags_d  = {3'b000, guard | sticky};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_cls_q    <= CLS_NORM;
      s1_exp_q    <= '0;
      s1_sig_a_q  <= '0;
      s1_sig_b_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_cls_q    <= CLS_NORM;
      s2_exp_q    <= '0;
      s2_prod_q   <= '0;
      s3_valid_q  <= 1'b0;
      s3_result_q <= '0;
      s3_flags_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_cls_q    <= s1_cls_d;
      s1_exp_q    <= s1_exp_d;
      s1_sig_a_q  <= s1_sig_a_d;
      s1_sig_b_q  <= s1_sig_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_cls_q    <= s2_cls_d;
      s2_exp_q    <= s2_exp_d;
      s2_prod_q   <= s2_prod_d;
      s3_valid_q  <= s3_valid_d;
      s3_result_q <= s3_result_d;
      s3_flags_q  <= s3_flags_d;
    end
  end

  always_comb begin
    out_valid  = s3_valid_q;
    out_result = s3_result_q;
    out_flags  = s3_flags_q;
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed vector table (single and half precision), streamed
// random operands against an arithmetic reference model, and a mid-stream reset.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_result;
  logic [3:0]  out_flags;
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_result;
  logic [3:0]  h_flags;

  fp_mul_pipe dut (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clock(clk), .reset(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_a(h_a), .in_b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_result(h_result), .out_flags(h_flags)
  );

  typedef struct {
    string       name;
    bit          half;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  vec_t vecs[17];
  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  int   out_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: exact integer product, then round-half-even by remainder comparison.
  function automatic void model(input int ew, input int mw, input longint a, input longint b,
                                output longint res, output logic [3:0] fl);
    longint one   = 1;
    longint emask = (one << ew) - 1;
    longint mmask = (one << mw) - 1;
    longint bias  = (one << (ew - 1)) - 1;
    longint ea    = (a >> mw) & emask;
    longint eb    = (b >> mw) & emask;
    longint ma    = a & mmask;
    longint mb    = b & mmask;
    longint sign  = ((a >> (ew + mw)) ^ (b >> (ew + mw))) & 1;
    longint inf_w = (sign << (ew + mw)) | (emask << mw);
    longint p, keep, rem, half, e;
    int     msb, sh;
    bit     a_zero = (ea == 0), b_zero = (eb == 0);
    bit     a_inf  = (ea == emask) && (ma == 0), b_inf = (eb == emask) && (mb == 0);
    bit     a_nan  = (ea == emask) && (ma != 0), b_nan = (eb == emask) && (mb != 0);
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      res = (emask << mw) | (one << (mw - 1));
      fl  = 4'b1000;
    end else if (a_inf || b_inf) begin
      res = inf_w;
      fl  = 4'b0000;
    end else if (a_zero || b_zero) begin
      res = sign << (ew + mw);
      fl  = 4'b0000;
    end else begin
      p   = ((one << mw) | ma) * ((one << mw) | mb);
      msb = 0;
      for (int i = 0; i < 64; i++) if (p[i]) msb = i;
      sh   = msb - mw;
      keep = p >> sh;
      rem  = p - (keep << sh);
      half = one << (sh - 1);
      e    = ea + eb - bias + longint'(msb - 2 * mw);
      if (rem > half || (rem == half && keep[0])) keep++;
      if (keep == (one << (mw + 1))) begin
        keep = keep >> 1;
        e++;
      end
      if (e >= emask) begin
        res = inf_w;
        fl  = 4'b0101;
      end else if (e <= 0) begin
        res = sign << (ew + mw);
        fl  = 4'b0011;
      end else begin
        res = (sign << (ew + mw)) | (e << mw) | (keep & mmask);
        fl  = {3'b000, rem != 0};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    int unsigned k = $urandom_range(99);
    logic        s = 1'($urandom);
    logic [7:0]  e;
    logic [22:0] m = 23'($urandom);
    if (k < 8) e = 8'd0;
    else if (k < 13) begin e = 8'hFF; m = '0; end
    else if (k < 17) begin e = 8'hFF; m = m | 23'd1; end
    else if (k < 60) e = 8'($urandom_range(107, 147));
    else e = 8'($urandom_range(1, 254));
    return {s, e, m};
  endfunction

  // Stream monitor: handshake rule, hold-during-stall, in-order scoreboard.
  bit          held = 1'b0;
  logic [31:0] held_r;
  logic [3:0]  held_f;
  exp_t        mon_e;
  longint      mon_res;
  logic [3:0]  mon_fl;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (held) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_result", out_result, held_r);
        check("hold_flags", out_flags, held_f);
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
        else begin
          mon_e = exp_q.pop_front();
          check("stream_result", out_result, mon_e.r);
          check("stream_flags", out_flags, mon_e.f);
        end
      end
      held   = out_valid && !out_ready;
      held_r = out_result;
      held_f = out_flags;
      if (in_valid && in_ready) begin
        model(8, 23, longint'(in_a), longint'(in_b), mon_res, mon_fl);
        mon_e.r = 32'(mon_res);
        mon_e.f = mon_fl;
        exp_q.push_back(mon_e);
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    out_ready = 1'b1;
    if (v.half) begin
      h_in_valid = 1'b1; h_a = v.a[15:0]; h_b = v.b[15:0];
    end else begin
      in_valid = 1'b1; in_a = v.a; in_b = v.b;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; h_in_valid = 1'b0;
    check({v.name, " lat1"}, v.half ? h_out_valid : out_valid, 1'b0);
    @(posedge clk); #1;
    check({v.name, " lat2"}, v.half ? h_out_valid : out_valid, 1'b0);
    @(posedge clk); #1;
    check({v.name, " valid"}, v.half ? h_out_valid : out_valid, 1'b1);
    if (v.half) begin
      check({v.name, " result"}, h_result, v.r[15:0]);
      check({v.name, " flags"}, h_flags, v.f);
    end else begin
      check({v.name, " result"}, out_result, v.r);
      check({v.name, " flags"}, out_flags, v.f);
    end
  endtask

  // mode 0: back-to-back inputs with out_ready toggling; mode 1: random valid/ready.
  task automatic stream(input int n, input int mode);
    int sent = 0;
    int cyc = 0;
    int guard = 0;
    bit xfer;
    out_cnt = 0;
    exp_q.delete();
    mon_en = 1'b1;
    while (sent < n && guard < 5000) begin
      out_ready = (mode == 0) ? (cyc % 2 == 0) : ($urandom_range(9) < 6);
      if (!in_valid && (mode == 0 || $urandom_range(3) != 0)) begin
        in_valid = 1'b1; in_a = rand_op(); in_b = rand_op();
      end
      @(negedge clk);
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++; guard++;
      if (xfer) begin sent++; in_valid = 1'b0; end
    end
    in_valid = 1'b0;
    check("stream_sent", sent, n);
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      out_ready = (mode == 0) ? (cyc % 2 == 0) : ($urandom_range(9) < 6);
      @(posedge clk); #1;
      cyc++; guard++;
    end
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("stream_drain_empty", exp_q.size(), 0);
    check("stream_out_count", out_cnt, n);
    mon_en = 1'b0;
  endtask

  task automatic reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = rand_op(); in_b = rand_op();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_mid pipe_full", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid out_valid", out_valid, 1'b0);
    check("rst_mid out_result", out_result, 32'h0);
    check("rst_mid out_flags", out_flags, 4'h0);
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_mid in_ready", in_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_mid no_stale", out_valid, 1'b0);
    end
    run_vec(vecs[0]);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_a = '0; h_b = '0; h_out_ready = 1'b1;

    vecs[0]  = '{"mul_2x3",       1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000};
    vecs[1]  = '{"norm_1p5sq",    1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000};
    vecs[2]  = '{"round_sticky",  1'b0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
    vecs[3]  = '{"tie_round_up",  1'b0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001};
    vecs[4]  = '{"tie_to_even",   1'b0, 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001};
    vecs[5]  = '{"round_carry",   1'b0, 32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 4'b0001};
    vecs[6]  = '{"zero_x_inf",    1'b0, 32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000};
    vecs[7]  = '{"overflow",      1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101};
    vecs[8]  = '{"underflow",     1'b0, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011};
    vecs[9]  = '{"neg_sign",      1'b0, 32'hBF800000, 32'h40000000, 32'hC0000000, 4'b0000};
    vecs[10] = '{"nan_in",        1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000};
    vecs[11] = '{"neg_inf",       1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
    vecs[12] = '{"neg_zero",      1'b0, 32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000};
    vecs[13] = '{"denorm_flush",  1'b0, 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000};
    vecs[14] = '{"negzero_x_inf", 1'b0, 32'h80000000, 32'hFF800000, 32'h7FC00000, 4'b1000};
    vecs[15] = '{"half_2x3",      1'b1, 32'h00004000, 32'h00004200, 32'h00004600, 4'b0000};
    vecs[16] = '{"half_overflow", 1'b1, 32'h00007BFF, 32'h00004000, 32'h00007C00, 4'b0101};

    #12;
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_result", out_result, 32'h0);
    check("reset out_flags", out_flags, 4'h0);
    check("reset half out_valid", h_out_valid, 1'b0);
    #11 rst = 1'b0;
    #1;
    check("post_reset in_ready", in_ready, 1'b1);
    check("post_reset half in_ready", h_in_ready, 1'b1);

    foreach (vecs[i]) run_vec(vecs[i]);

    stream(8, 0);
    stream(300, 1);
    reset_mid();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
